// File: rtl/hazard_controller.sv
// Pipeline hazard unit: operand forwarding, load-use stall, branch flush and data-memory wait/timeout FSM.
// Optional performance counters (StallCycles, FlushCount) are enabled by defining HAZARD_PERF_CNT_EN.
module hazard_controller #(
    parameter logic [7:0] MEM_TIMEOUT = 8'd255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] Rs1D,
    input  logic [4:0] Rs2D,
    input  logic [4:0] Rs1E,
    input  logic [4:0] Rs2E,
    input  logic [4:0] RdE,
    input  logic [4:0] RdM,
    input  logic [4:0] RdW,
    input  logic       RegWriteM,
    input  logic       RegWriteW,
    input  logic [1:0] ResultSrcE,
    input  logic       PCSrcE,
    input  logic       MemAccessM,
    input  logic       MemReadyM,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE,
    output logic       StallF,
    output logic       StallD,
    output logic       StallE,
    output logic       StallM,
    output logic       FlushD,
    output logic       FlushE,
    output logic       FlushW,
    output logic       MemErr
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] StallCycles,
    output logic [31:0] FlushCount
`endif
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'b00,
        ST_WAIT = 2'b01,
        ST_ERR  = 2'b10
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       mem_err_q, mem_err_d;
    logic       mem_hold;
    logic       load_use;

    function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
        if (RegWriteM && (RdM != 5'd0) && (RdM == rs))      return 2'b10;
        else if (RegWriteW && (RdW != 5'd0) && (RdW == rs)) return 2'b01;
        else                                                return 2'b00;
    endfunction

    assign load_use = (ResultSrcE == 2'b01) && (RdE != 5'd0) &&
                      ((RdE == Rs1D) || (RdE == Rs2D));

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        mem_err_d  = mem_err_q;
        mem_hold   = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (MemAccessM && !MemReadyM) begin
                    mem_hold   = 1'b1;
                    state_d    = ST_WAIT;
                    wait_cnt_d = 8'd0;
                end
            end
            ST_WAIT: begin
                if (MemReadyM) begin
                    state_d    = ST_RUN;
                    wait_cnt_d = 8'd0;
                end else begin
                    mem_hold = 1'b1;
                    if (wait_cnt_q == MEM_TIMEOUT) begin
                        state_d   = ST_ERR;
                        mem_err_d = 1'b1;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 8'd1;
                    end
                end
            end
            ST_ERR:  mem_hold = 1'b1;
            default: state_d = ST_RUN;
        endcase
    end

    // Memory stall dominates; otherwise a taken branch beats a load-use stall.
    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        StallM    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        FlushW    = 1'b0;
        if (!rst) begin
            ForwardAE = fwd_sel(Rs1E);
            ForwardBE = fwd_sel(Rs2E);
            if (mem_hold) begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
                FlushW = 1'b1;
            end else if (PCSrcE) begin
                FlushD = 1'b1;
                FlushE = 1'b1;
            end else if (load_use) begin
                StallF = 1'b1;
                StallD = 1'b1;
                FlushE = 1'b1;
            end
        end
    end

    assign MemErr = mem_err_q;

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RUN;
            wait_cnt_q <= 8'd0;
            mem_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            mem_err_q  <= mem_err_d;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [31:0] flush_count_q, flush_count_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q + {31'd0, StallF};
        flush_count_d  = flush_count_q + {31'd0, FlushE};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_q <= 32'd0;
            flush_count_q  <= 32'd0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    assign StallCycles = stall_cycles_q;
    assign FlushCount  = flush_count_q;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Testbench for hazard_controller: directed scenarios plus randomized traffic against a rule-level reference model.
// Define HAZARD_PERF_CNT_EN to also check the performance counters.
module tb_hazard_controller;

    localparam logic [7:0] TIMEOUT = 8'd4;

    logic       clk;
    logic       rst;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic       RegWriteM, RegWriteW;
    logic [1:0] ResultSrcE;
    logic       PCSrcE, MemAccessM, MemReadyM;
    logic [1:0] ForwardAE, ForwardBE;
    logic       StallF, StallD, StallE, StallM;
    logic       FlushD, FlushE, FlushW;
    logic       MemErr;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] StallCycles, FlushCount;
`endif

    hazard_controller #(.MEM_TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE),
        .MemAccessM(MemAccessM), .MemReadyM(MemReadyM),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .MemErr(MemErr)
`ifdef HAZARD_PERF_CNT_EN
        , .StallCycles(StallCycles), .FlushCount(FlushCount)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total    = 0;
    int fail_cnt = 0;

    // Reference model: waiting flag, cycles already waited, sticky error, perf tallies.
    bit          m_valid = 0;
    bit          m_wait  = 0;
    int          m_waited = 0;
    bit          m_err   = 0;
    longint      m_stalls = 0;
    longint      m_flushes = 0;

    logic [1:0] e_fa, e_fb;
    logic [3:0] e_stall;
    logic [2:0] e_flush;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] fwd_ref(input logic [4:0] rs);
        if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
        if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    task automatic expect_now();
        bit hold, lu;
        e_fa = 2'b00; e_fb = 2'b00; e_stall = 4'b0000; e_flush = 3'b000;
        if (!rst) begin
            e_fa = fwd_ref(Rs1E);
            e_fb = fwd_ref(Rs2E);
            hold = m_err || (m_wait ? !MemReadyM : (MemAccessM && !MemReadyM));
            lu   = (ResultSrcE == 2'b01) && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
            if (hold)        begin e_stall = 4'b1111; e_flush = 3'b001; end
            else if (PCSrcE) e_flush = 3'b110;
            else if (lu)     begin e_stall = 4'b1100; e_flush = 3'b010; end
        end
    endtask

    task automatic update_model();
        if (rst) begin
            m_valid = 1; m_wait = 0; m_waited = 0; m_err = 0;
            m_stalls = 0; m_flushes = 0;
        end else begin
            m_stalls  += e_stall[3];
            m_flushes += e_flush[1];
            if (m_err) begin
            end else if (m_wait) begin
                if (MemReadyM) begin m_wait = 0; m_waited = 0; end
                else if (m_waited == int'(TIMEOUT)) m_err = 1;
                else m_waited++;
            end else if (MemAccessM && !MemReadyM) begin
                m_wait = 1; m_waited = 0;
            end
        end
    endtask

    // One clock cycle: compare against the model mid-cycle, then advance.
    task automatic tick();
        #1;
        expect_now();
        check("ForwardAE", 32'(ForwardAE), 32'(e_fa));
        check("ForwardBE", 32'(ForwardBE), 32'(e_fb));
        check("stall_FDEM", 32'({StallF, StallD, StallE, StallM}), 32'(e_stall));
        check("flush_DEW", 32'({FlushD, FlushE, FlushW}), 32'(e_flush));
        if (m_valid) begin
            check("MemErr", 32'(MemErr), 32'(m_err));
`ifdef HAZARD_PERF_CNT_EN
            check("StallCycles", StallCycles, 32'(m_stalls));
            check("FlushCount", FlushCount, 32'(m_flushes));
`endif
        end
        @(posedge clk);
        update_model();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
        RegWriteM = 0; RegWriteW = 0; ResultSrcE = 0;
        PCSrcE = 0; MemAccessM = 0; MemReadyM = 1;
    endtask

    task automatic do_reset();
        rst = 1; tick(); rst = 0;
    endtask

    initial begin
        // Reset with hazards present on every input: outputs must stay quiet.
        idle_inputs();
        rst = 1;
        Rs1E = 5; RdM = 5; RegWriteM = 1; ResultSrcE = 2'b01; RdE = 7; Rs2D = 7;
        PCSrcE = 1; MemAccessM = 1; MemReadyM = 0;
        #1;
        check("rst_quiet", 32'({ForwardAE, StallF, StallD, FlushD, FlushE, FlushW, StallM}), 32'd0);
        tick();
        rst = 0;
        idle_inputs();
        tick();

        // Forwarding priority: M over W, falling back to W when RdM is x0.
        Rs1E = 5; RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1;
        #1 check("fwdA_M", 32'(ForwardAE), 32'h2);
        RdM = 0;
        #1 check("fwdA_W", 32'(ForwardAE), 32'h1);
        tick();
        Rs2E = 9; RdW = 9; RdM = 9; RegWriteM = 0;
        #1 check("fwdB_W", 32'(ForwardBE), 32'h1);
        tick();
        idle_inputs();

        // Load-use stall lasts one cycle, then clears.
        ResultSrcE = 2'b01; RdE = 7; Rs2D = 7;
        #1 check("lu_stall", 32'({StallF, StallD, FlushE, FlushD}), 32'b1110);
        tick();
        ResultSrcE = 2'b00;
        #1 check("lu_gone", 32'({StallF, StallD, FlushE, FlushD}), 32'b0000);
        tick();

        // Branch beats load-use.
        ResultSrcE = 2'b01; RdE = 7; Rs2D = 7; PCSrcE = 1;
        #1 check("br_wins", 32'({FlushD, FlushE, StallF, StallD}), 32'b1100);
        tick();
        idle_inputs();

        // Three not-ready cycles then ready; branch is suppressed while holding.
        MemAccessM = 1; MemReadyM = 0; PCSrcE = 1;
        for (int i = 0; i < 3; i++) begin
            #1 check("memwait_stallM", 32'({StallM, FlushW, FlushD, FlushE}), 32'b1100);
            tick();
        end
        MemReadyM = 1;
        #1 check("memready_release", 32'({StallM, StallF, FlushW}), 32'd0);
        tick();
        idle_inputs();
        #1 check("run_after_wait", 32'({StallF, StallM}), 32'd0);
        tick();

        // Timeout: RUN stall + waits through counter==TIMEOUT, then sticky ERR.
        MemAccessM = 1; MemReadyM = 0;
        for (int i = 0; i < int'(TIMEOUT) + 2; i++) tick();
        MemAccessM = 0; MemReadyM = 1;
        #1 check("err_flag", 32'(MemErr), 32'd1);
        check("err_stuck", 32'({StallF, StallD, StallE, StallM, FlushW}), 32'h1f);
        tick();
        tick();
        do_reset();
        #1 check("err_cleared", 32'({MemErr, StallF, StallM, FlushW}), 32'd0);
        tick();

`ifdef HAZARD_PERF_CNT_EN
        // Two load-use stalls and one branch.
        do_reset();
        for (int i = 0; i < 2; i++) begin
            ResultSrcE = 2'b01; RdE = 3; Rs1D = 3; tick();
            idle_inputs(); tick();
        end
        PCSrcE = 1; tick();
        idle_inputs();
        #1 check("perf_stalls", StallCycles, 32'd2);
        check("perf_flushes", FlushCount, 32'd3);
        tick();
`endif

        // Randomized traffic with alternating slow/fast memory phases.
        for (int i = 0; i < 400; i++) begin
            rst        = ($urandom_range(0, 59) == 0);
            Rs1D       = 5'($urandom_range(0, 3));
            Rs2D       = 5'($urandom_range(0, 3));
            Rs1E       = 5'($urandom_range(0, 3));
            Rs2E       = 5'($urandom_range(0, 3));
            RdE        = 5'($urandom_range(0, 3));
            RdM        = 5'($urandom_range(0, 3));
            RdW        = 5'($urandom_range(0, 3));
            RegWriteM  = 1'($urandom_range(0, 1));
            RegWriteW  = 1'($urandom_range(0, 1));
            ResultSrcE = 2'($urandom_range(0, 3));
            PCSrcE     = ($urandom_range(0, 4) == 0);
            MemAccessM = ($urandom_range(0, 2) == 0);
            MemReadyM  = ((i % 100) < 30) ? ($urandom_range(0, 7) == 0)
                                          : ($urandom_range(0, 3) != 0);
            tick();
        end
        rst = 0;

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

// File: doc/hazard_controller.md
HAZARD_CONTROLLER -- requirements
Module: hazard_controller

Interface
REQ-001 Parameter: MEM_TIMEOUT, default 8'd255, maximum data-memory wait cycles before error.
REQ-002 Port: clk  in  1  single clock; all state updates on posedge.
REQ-003 Port: rst  in  1  synchronous, active-high reset.
REQ-004 Ports: Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW  in  5 each  register addresses per stage.
REQ-005 Ports: RegWriteM, RegWriteW  in  1  writeback enables in M and W.
REQ-006 Port: ResultSrcE  in  2  result select in E; 2'b01 marks a load.
REQ-007 Ports: PCSrcE  in  1  taken branch/jump; MemAccessM  in  1  load/store in M; MemReadyM  in  1  data memory ready.
REQ-008 Ports: ForwardAE, ForwardBE  out  2  operand forwarding select (00 reg file, 01 W result, 10 M ALU result).
REQ-009 Ports: StallF, StallD, StallE, StallM  out  1  hold stage registers; FlushD, FlushE, FlushW  out  1  insert bubble.
REQ-010 Port: MemErr  out  1  sticky memory-timeout flag.

Function
REQ-011 ForwardAE SHALL be 10 if RegWriteM, RdM!=0 and RdM==Rs1E; else 01 if RegWriteW, RdW!=0 and RdW==Rs1E; else 00; ForwardBE the same using Rs2E.
REQ-012 Load-use hazard: ResultSrcE==2'b01, RdE!=0 and RdE equal to Rs1D or Rs2D.
REQ-013 Load-use in RUN SHALL assert StallF, StallD and FlushE in the same cycle; the stall lasts one cycle.
REQ-014 PCSrcE in RUN SHALL assert FlushD and FlushE.
REQ-015 If PCSrcE and a load-use hazard occur together, the flush SHALL win: FlushD=FlushE=1 and StallF=StallD=0.
REQ-016 FSM states: RUN, WAIT, ERR (2-bit encoding).
REQ-017 RUN with MemAccessM=1 and MemReadyM=0 SHALL assert StallF/D/E/M and FlushW in that cycle and go to WAIT.
REQ-018 RUN with MemAccessM=1 and MemReadyM=1 SHALL not stall.
REQ-019 WAIT with MemReadyM=0 SHALL assert StallF/D/E/M and FlushW, and increment the 8-bit wait counter.
REQ-020 WAIT with MemReadyM=1 SHALL deassert all memory stalls that cycle, clear the counter and return to RUN.
REQ-021 WAIT with counter==MEM_TIMEOUT and MemReadyM=0 SHALL go to ERR.
REQ-022 The memory stall SHALL override load-use and branch handling: FlushD=FlushE=0 while it is asserted, and PCSrcE is held in the stalled E stage.
REQ-023 ERR SHALL set MemErr=1 and hold StallF/D/E/M=1 and FlushW=1 until rst.
REQ-024 Forwarding SHALL be evaluated in every state, including WAIT and ERR.

Reset
REQ-025 On rst: state RUN, wait counter 0, MemErr 0, perf counters 0.
REQ-026 While rst=1: all stall and flush outputs 0, ForwardAE=ForwardBE=00.
REQ-027 rst asserted during WAIT or ERR SHALL return to RUN on the next posedge with no residual stall.

Configuration
REQ-028 Macro HAZARD_PERF_CNT_EN defined: adds outputs StallCycles[31:0] and FlushCount[31:0].
REQ-029 StallCycles SHALL increment each cycle StallF=1; FlushCount SHALL increment each cycle FlushE=1; both wrap at 2^32.
REQ-030 Macro HAZARD_PERF_CNT_EN undefined: no counter ports or logic; all other behaviour identical.

Verification
REQ-031 Rs1E=5, RdM=5, RegWriteM=1, RdW=5, RegWriteW=1 -> ForwardAE=10; with RdM=0 -> ForwardAE=01.
REQ-032 ResultSrcE=01, RdE=7, Rs2D=7 -> StallF=StallD=FlushE=1 for one cycle; next cycle with the hazard gone -> all 0.
REQ-033 Same load-use plus PCSrcE=1 -> FlushD=FlushE=1, StallF=0.
REQ-034 MemAccessM=1, MemReadyM low for 3 cycles then high -> StallM=1 for 3 cycles, 0 on the ready cycle, state RUN after.
REQ-035 MemReadyM held 0 with MEM_TIMEOUT=4 -> ERR after the timeout is reached, MemErr=1 and stalls stuck high; rst -> MemErr=0, state RUN.
REQ-036 With HAZARD_PERF_CNT_EN defined: 2 load-use stalls plus 1 branch -> StallCycles=2, FlushCount=3.
